// File: rtl/cm811_check_ram_if.sv
// Single-port synchronous RAM port as seen by the check-RAM responder.
// The responder is the master; the RAM (or the port mux towards it) is the slave.
interface cm811_check_ram_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_addr,
        output ram_wr_en,
        output ram_wdata,
        output ram_rd_en,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_wr_en,
        input  ram_wdata,
        input  ram_rd_en,
        output ram_rdata
    );
endinterface

// File: rtl/cm811_check_ram.sv
// Check-RAM responder: three write/readback passes (0x55.., 0xAA.., address) over
// words 0..DEPTH-1, answering each start with exactly one done or error pulse.
module cm811_check_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                 sys_clk,
    input  logic                 glbl_rst_n,
    input  logic                 check_ram_en,
    output logic                 check_ram_done,
    output logic                 check_ram_error,
    output logic                 busy,
    cm811_check_ram_if.master    ram,
    output logic [ADDR_W-1:0]    fail_addr,
    output logic [DATA_W-1:0]    fail_exp,
    output logic [DATA_W-1:0]    fail_act
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_CMP,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [DATA_W-1:0] P0        = {(DATA_W/2){2'b01}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        LAT_LAST  = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [1:0]        LAST_PASS = 2'd2;

    state_t            state_reg;
    logic [1:0]        pass_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        lat_reg;
    logic              done_reg;
    logic              error_reg;
    logic              busy_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic              ram_wr_en_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              ram_rd_en_reg;
    logic [ADDR_W-1:0] fail_addr_reg;
    logic [DATA_W-1:0] fail_exp_reg;
    logic [DATA_W-1:0] fail_act_reg;

    logic [ADDR_W-1:0] addr_next;
    logic [1:0]        pass_next;
    logic [DATA_W-1:0] exp_data;

    // Address pattern is zero-extended or truncated to the data width.
    function automatic logic [DATA_W-1:0] pattern_of(input logic [1:0]        p,
                                                     input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] wide;
        wide = {{DATA_W{1'b0}}, a};
        case (p)
            2'd0:    return P0;
            2'd1:    return ~P0;
            default: return wide[DATA_W-1:0];
        endcase
    endfunction

    assign addr_next = addr_reg + 1'b1;
    assign pass_next = pass_reg + 2'd1;
    assign exp_data  = pattern_of(pass_reg, addr_reg);

    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state_reg     <= S_IDLE;
            pass_reg      <= '0;
            addr_reg      <= '0;
            lat_reg       <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wr_en_reg <= 1'b0;
            ram_wdata_reg <= '0;
            ram_rd_en_reg <= 1'b0;
            fail_addr_reg <= '0;
            fail_exp_reg  <= '0;
            fail_act_reg  <= '0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (check_ram_en) begin
                        state_reg     <= S_WR;
                        pass_reg      <= '0;
                        addr_reg      <= '0;
                        busy_reg      <= 1'b1;
                        ram_wr_en_reg <= 1'b1;
                        ram_addr_reg  <= '0;
                        ram_wdata_reg <= P0;
                        fail_addr_reg <= '0;
                        fail_exp_reg  <= '0;
                        fail_act_reg  <= '0;
                    end
                end

                S_WR: begin
                    if (addr_reg == LAST_ADDR) begin
                        state_reg     <= S_RD;
                        addr_reg      <= '0;
                        ram_wr_en_reg <= 1'b0;
                        ram_wdata_reg <= '0;
                        ram_rd_en_reg <= 1'b1;
                        ram_addr_reg  <= '0;
                    end else begin
                        addr_reg      <= addr_next;
                        ram_addr_reg  <= addr_next;
                        ram_wdata_reg <= pattern_of(pass_reg, addr_next);
                    end
                end

                S_RD: begin
                    ram_rd_en_reg <= 1'b0;
                    lat_reg       <= '0;
                    state_reg     <= (RD_LAT == 1) ? S_CMP : S_WAIT;
                end

                S_WAIT: begin
                    if (lat_reg == LAT_LAST) begin
                        state_reg <= S_CMP;
                    end else begin
                        lat_reg <= lat_reg + 2'd1;
                    end
                end

                S_CMP: begin
                    if (ram.ram_rdata != exp_data) begin
                        state_reg     <= S_FAIL;
                        error_reg     <= 1'b1;
                        ram_addr_reg  <= '0;
                        fail_addr_reg <= addr_reg;
                        fail_exp_reg  <= exp_data;
                        fail_act_reg  <= ram.ram_rdata;
                    end else if (addr_reg != LAST_ADDR) begin
                        state_reg     <= S_RD;
                        addr_reg      <= addr_next;
                        ram_addr_reg  <= addr_next;
                        ram_rd_en_reg <= 1'b1;
                    end else if (pass_reg != LAST_PASS) begin
                        state_reg     <= S_WR;
                        pass_reg      <= pass_next;
                        addr_reg      <= '0;
                        ram_addr_reg  <= '0;
                        ram_wr_en_reg <= 1'b1;
                        ram_wdata_reg <= pattern_of(pass_next, '0);
                    end else begin
                        state_reg    <= S_DONE;
                        done_reg     <= 1'b1;
                        ram_addr_reg <= '0;
                    end
                end

                // Start requests arriving during the pulse cycle are dropped here.
                S_DONE, S_FAIL: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end

                default: begin
                    state_reg     <= S_IDLE;
                    busy_reg      <= 1'b0;
                    ram_addr_reg  <= '0;
                    ram_wr_en_reg <= 1'b0;
                    ram_wdata_reg <= '0;
                    ram_rd_en_reg <= 1'b0;
                end
            endcase
        end
    end

    assign check_ram_done  = done_reg;
    assign check_ram_error = error_reg;
    assign busy            = busy_reg;
    assign ram.ram_addr    = ram_addr_reg;
    assign ram.ram_wr_en   = ram_wr_en_reg;
    assign ram.ram_wdata   = ram_wdata_reg;
    assign ram.ram_rd_en   = ram_rd_en_reg;
    assign fail_addr       = fail_addr_reg;
    assign fail_exp        = fail_exp_reg;
    assign fail_act        = fail_act_reg;

endmodule

// File: tb/tb_cm811_check_ram.sv
// Bench for cm811_check_ram: two instances (read latency 1 and 3) against faulty RAM
// models, with outcomes predicted by replaying the three passes over an array.
module tb_cm811_check_ram;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int NI     = 2;
    localparam int BUDGET = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n_a  [NI];
    logic              en_a     [NI];
    logic              done_a   [NI];
    logic              err_a    [NI];
    logic              busy_a   [NI];
    logic [ADDR_W-1:0] addr_a   [NI];
    logic              wr_a     [NI];
    logic              rd_a     [NI];
    logic [DATA_W-1:0] wdata_a  [NI];
    logic [ADDR_W-1:0] faddr_a  [NI];
    logic [DATA_W-1:0] fexp_a   [NI];
    logic [DATA_W-1:0] fact_a   [NI];

    // Fault description: 0 none, 1 bit f_bit of word f_addr stuck at f_val, 2 address bit f_bit ignored.
    int f_mode [NI];
    int f_addr [NI];
    int f_bit  [NI];
    int f_val  [NI];

    int rel [NI], wr_cnt [NI], rd_cnt [NI], done_cnt [NI], done_cyc [NI];
    int err_cnt [NI], err_cyc [NI], both_pulse [NI], both_str [NI], idle_viol [NI];
    int post_str [NI], busy_cnt [NI], busy_first [NI], busy_last [NI], pulsed [NI];

    int n_vec;
    int n_miscmp;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int eff_addr(input int k, input int a);
        if (f_mode[k] == 2) return a & ~(1 << f_bit[k]);
        return a;
    endfunction

    function automatic logic [15:0] rd_fault(input int k, input int a, input logic [15:0] d);
        logic [15:0] r;
        r = d;
        if (f_mode[k] == 1 && a == f_addr[k]) r[f_bit[k]] = f_val[k][0];
        return r;
    endfunction

    function automatic logic [15:0] pat(input int p, input int a);
        case (p)
            0:       return 16'h5555;
            1:       return 16'hAAAA;
            default: return 16'(a);
        endcase
    endfunction

    // Replays write-all / read-all per pass over a faulty memory; stops at the first bad word.
    function automatic void predict(input int k, output bit fl, output int fp, output int fa,
                                    output logic [15:0] fe, output logic [15:0] fx);
        logic [15:0] m [DEPTH];
        logic [15:0] v;
        fl = 1'b0; fp = 0; fa = 0; fe = '0; fx = '0;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < DEPTH; a++) m[eff_addr(k, a)] = pat(p, a);
            for (int a = 0; a < DEPTH; a++) begin
                v = rd_fault(k, a, m[eff_addr(k, a)]);
                if (v != pat(p, a)) begin
                    fl = 1'b1; fp = p; fa = a; fe = pat(p, a); fx = v;
                    return;
                end
            end
        end
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 1 : 3;

        cm811_check_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_if ();

        cm811_check_ram #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .RD_LAT (LAT)
        ) dut (
            .sys_clk         (clk),
            .glbl_rst_n      (rst_n_a[gi]),
            .check_ram_en    (en_a[gi]),
            .check_ram_done  (done_a[gi]),
            .check_ram_error (err_a[gi]),
            .busy            (busy_a[gi]),
            .ram             (ram_if),
            .fail_addr       (faddr_a[gi]),
            .fail_exp        (fexp_a[gi]),
            .fail_act        (fact_a[gi])
        );

        logic [15:0] mem  [1024];
        logic [15:0] pipe [4];

        assign addr_a[gi]       = ram_if.ram_addr;
        assign wr_a[gi]         = ram_if.ram_wr_en;
        assign rd_a[gi]         = ram_if.ram_rd_en;
        assign wdata_a[gi]      = ram_if.ram_wdata;
        assign ram_if.ram_rdata = pipe[LAT-1];

        // Read data is valid for exactly one cycle, LAT cycles after the strobe; junk otherwise.
        always @(posedge clk) begin
            if (ram_if.ram_wr_en) mem[eff_addr(gi, int'(ram_if.ram_addr))] <= ram_if.ram_wdata;
            pipe[0] <= ram_if.ram_rd_en
                       ? rd_fault(gi, int'(ram_if.ram_addr), mem[eff_addr(gi, int'(ram_if.ram_addr))])
                       : 16'($urandom);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        initial begin
            forever begin
                @(negedge clk);
                rel[gi]++;
                if (pulsed[gi] != 0 && (wr_a[gi] || rd_a[gi])) post_str[gi]++;
                if (wr_a[gi]) wr_cnt[gi]++;
                if (rd_a[gi]) rd_cnt[gi]++;
                if (wr_a[gi] && rd_a[gi]) both_str[gi]++;
                if (done_a[gi] && err_a[gi]) both_pulse[gi]++;
                if (done_a[gi]) begin done_cnt[gi]++; done_cyc[gi] = rel[gi]; end
                if (err_a[gi]) begin err_cnt[gi]++; err_cyc[gi] = rel[gi]; end
                if (done_a[gi] || err_a[gi]) pulsed[gi] = 1;
                if (!busy_a[gi] && (wr_a[gi] || rd_a[gi] || addr_a[gi] != '0 || wdata_a[gi] != '0))
                    idle_viol[gi]++;
                if (busy_a[gi]) begin
                    busy_cnt[gi]++;
                    if (busy_first[gi] < 0) busy_first[gi] = rel[gi];
                    busy_last[gi] = rel[gi];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats(input int k);
        rel[k] = -1; wr_cnt[k] = 0; rd_cnt[k] = 0; done_cnt[k] = 0; done_cyc[k] = -1;
        err_cnt[k] = 0; err_cyc[k] = -1; both_pulse[k] = 0; both_str[k] = 0; idle_viol[k] = 0;
        post_str[k] = 0; busy_cnt[k] = 0; busy_first[k] = -1; busy_last[k] = -1; pulsed[k] = 0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_nonzero(input int k);
        return {22'd0, busy_a[k], done_a[k], err_a[k], wr_a[k], rd_a[k],
                addr_a[k] != '0, wdata_a[k] != '0, faddr_a[k] != '0,
                fexp_a[k] != '0, fact_a[k] != '0};
    endfunction

    // One start transaction; spur>0 requests an extra en pulse in that cycle (clamped to the pulse cycle).
    task automatic run(input int k, input int mode, input int fa, input int fb, input int fv,
                       input int spur_in, input string name);
        bit          fl;
        int          fp, fad, pc, ew, er, stop_at, lat, spur;
        logic [15:0] fe, fx;
        string       tg;
        f_mode[k] = mode; f_addr[k] = fa; f_bit[k] = fb; f_val[k] = fv;
        predict(k, fl, fp, fad, fe, fx);
        lat = lat_of(k);
        pc  = fl ? fp*DEPTH*(lat+2) + DEPTH + 1 + fad*(lat+1) + lat + 1 : 3*DEPTH*(lat+2) + 1;
        ew  = fl ? (fp+1)*DEPTH : 3*DEPTH;
        er  = fl ? fp*DEPTH + fad + 1 : 3*DEPTH;
        spur = (spur_in > pc) ? pc : spur_in;
        tg = $sformatf("L%0d %s", lat, name);
        clear_stats(k);
        en_a[k] = 1'b1;
        stop_at = -1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(posedge clk);
            #1;
            en_a[k] = (spur != 0 && i == spur);
            if (i == 1) begin
                check_eq({tg, " fail_addr cleared"}, 32'(faddr_a[k]), 32'd0);
                check_eq({tg, " fail_exp cleared"}, 32'(fexp_a[k]), 32'd0);
                check_eq({tg, " fail_act cleared"}, 32'(fact_a[k]), 32'd0);
            end
            if (stop_at < 0 && pulsed[k] != 0) stop_at = i + 6;
            if (i == stop_at) break;
        end
        en_a[k] = 1'b0;
        check_eq({tg, " pulse seen"}, 32'(pulsed[k]), 32'd1);
        check_eq({tg, " done count"}, 32'(done_cnt[k]), fl ? 32'd0 : 32'd1);
        check_eq({tg, " error count"}, 32'(err_cnt[k]), fl ? 32'd1 : 32'd0);
        check_eq({tg, " pulse cycle"}, 32'(fl ? err_cyc[k] : done_cyc[k]), 32'(pc));
        check_eq({tg, " writes"}, 32'(wr_cnt[k]), 32'(ew));
        check_eq({tg, " reads"}, 32'(rd_cnt[k]), 32'(er));
        check_eq({tg, " busy first"}, 32'(busy_first[k]), 32'd1);
        check_eq({tg, " busy last"}, 32'(busy_last[k]), 32'(pc));
        check_eq({tg, " busy cycles"}, 32'(busy_cnt[k]), 32'(pc));
        check_eq({tg, " wr&rd overlap"}, 32'(both_str[k]), 32'd0);
        check_eq({tg, " done&err overlap"}, 32'(both_pulse[k]), 32'd0);
        check_eq({tg, " idle bus activity"}, 32'(idle_viol[k]), 32'd0);
        check_eq({tg, " strobes after pulse"}, 32'(post_str[k]), 32'd0);
        check_eq({tg, " fail_addr"}, 32'(faddr_a[k]), fl ? 32'(fad) : 32'd0);
        check_eq({tg, " fail_exp"}, 32'(fexp_a[k]), fl ? 32'(fe) : 32'd0);
        check_eq({tg, " fail_act"}, 32'(fact_a[k]), fl ? 32'(fx) : 32'd0);
        $display("run %s mode=%0d spur=%0d: %s expected in cycle %0d (pass %0d addr %0d exp 0x%04h act 0x%04h)",
                 tg, mode, spur, fl ? "error" : "done", pc, fp, fad, fe, fx);
    endtask

    task automatic reset_mid(input int k, input int rc);
        string tg;
        tg = $sformatf("L%0d reset@%0d", lat_of(k), rc);
        f_mode[k] = 0;
        clear_stats(k);
        en_a[k] = 1'b1;
        for (int i = 1; i <= rc; i++) begin
            @(posedge clk);
            #1;
            en_a[k] = 1'b0;
        end
        rst_n_a[k] = 1'b0;
        #1;
        check_eq({tg, " outputs zero"}, outs_nonzero(k), 32'd0);
        wait_cyc(4);
        rst_n_a[k] = 1'b1;
        wait_cyc(70);
        check_eq({tg, " no done"}, 32'(done_cnt[k]), 32'd0);
        check_eq({tg, " no error"}, 32'(err_cnt[k]), 32'd0);
        check_eq({tg, " idle after"}, outs_nonzero(k), 32'd0);
        $display("run %s: aborted, bus quiet", tg);
    endtask

    initial begin
        n_vec = 0;
        n_miscmp = 0;
        for (int k = 0; k < NI; k++) begin
            rst_n_a[k] = 1'b0; en_a[k] = 1'b0;
            f_mode[k] = 0; f_addr[k] = 0; f_bit[k] = 0; f_val[k] = 0;
            clear_stats(k);
        end
        wait_cyc(3);
        for (int k = 0; k < NI; k++)
            check_eq($sformatf("L%0d reset outputs", lat_of(k)), outs_nonzero(k), 32'd0);
        for (int k = 0; k < NI; k++) rst_n_a[k] = 1'b1;
        wait_cyc(2);

        for (int k = 0; k < NI; k++) begin
            run(k, 0, 0, 0, 0, 0, "clean");
            run(k, 1, 2, 0, 0, 0, "stuck a2 b0");
            run(k, 2, 0, 1, 0, 0, "alias b1");
            run(k, 0, 0, 0, 0, 10, "spurious en c10");
            reset_mid(k, 20);
            run(k, 0, 0, 0, 0, 0, "after reset");
            for (int r = 0; r < 12; r++) begin
                int mode, fa, fb, fv, spur;
                mode = $urandom_range(0, 2);
                fa   = $urandom_range(0, DEPTH-1);
                fb   = (mode == 2) ? $urandom_range(0, 1) : $urandom_range(0, 15);
                fv   = $urandom_range(0, 1);
                spur = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 70) : 0;
                wait_cyc($urandom_range(0, 3));
                run(k, mode, fa, fb, fv, spur, $sformatf("rand%0d", r));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
